// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and grant constants for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - two-way round-robin / fixed-priority grant picker
module rr_pick2
    import mem_arbiter_pkg::*;
#(
    parameter int D_PRIORITY = 0
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant
);

    // Lone requester wins; ties go to D or to the port opposite the last winner.
    always_comb begin
        grant = GNT_I;
        if (req_d && !req_i) begin
            grant = GNT_D;
        end else if (req_d && req_i) begin
            if (D_PRIORITY != 0) begin
                grant = GNT_D;
            end else begin
                grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache line arbiter for a shared memory port with watchdog
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int D_PRIORITY = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t             state;
    state_t             state_next;
    logic               last_grant;
    logic               grant;
    logic               req_i;
    logic               req_d;
    logic               in_busy;
    logic [CNT_W-1:0]   wait_cnt;

    assign req_i   = i_read;
    assign req_d   = d_read | d_write;
    assign in_busy = (state == I_BUSY) || (state == D_BUSY);
    assign busy    = (state != IDLE);

    rr_pick2 #(
        .D_PRIORITY (D_PRIORITY)
    ) u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: grant only from IDLE, finish on mem_ready, one DONE cycle for request drop.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    state_next = (grant == GNT_D) ? D_BUSY : I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered memory strobes, returned lines and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            last_grant <= GNT_I;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i || req_d) begin
                        last_grant <= grant;
                        if (grant == GNT_D) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_write <= d_write;
                            mem_read  <= !d_write;
                        end else begin
                            mem_addr  <= i_addr;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                        end
                    end
                end
                I_BUSY: begin
                    if (mem_ready) begin
                        i_rdata   <= mem_rdata;
                        i_ready   <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                D_BUSY: begin
                    if (mem_ready) begin
                        if (!mem_write) begin
                            d_rdata <= mem_rdata;
                        end
                        d_ready   <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Watchdog: count busy cycles (saturating), latch the error when the count hits TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_next == IDLE) begin
                wait_cnt <= '0;
            end else if (in_busy && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt == CNT_MAX - 1'b1) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (round-robin and D-priority instances)
module tb_mem_arbiter;

    localparam int MEM_WAIT = 5;

    typedef struct {
        logic         ir;
        logic         dr;
        logic         dw;
        logic [27:0]  ia;
        logic [27:0]  da;
        logic [127:0] wd;
        logic [1:0]   gd;
    } row_t;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic         d_read;
    logic         d_write;
    logic [27:0]  i_addr;
    logic [27:0]  d_addr;
    logic [127:0] d_wdata;
    logic         hold;

    logic [127:0] i_rdata_v   [2];
    logic         i_ready_v   [2];
    logic [127:0] d_rdata_v   [2];
    logic         d_ready_v   [2];
    logic         mem_read_v  [2];
    logic         mem_write_v [2];
    logic [27:0]  mem_addr_v  [2];
    logic [127:0] mem_wdata_v [2];
    logic [127:0] mem_rdata_v [2];
    logic         mem_ready_v [2];
    logic         busy_v      [2];
    logic         terr_v      [2];

    int           mcnt [2];
    logic [127:0] e_ird [2];
    logic [127:0] e_drd [2];
    row_t         rows [8];
    int           checks;
    int           failures;

    mem_arbiter #(.D_PRIORITY(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata_v[0]), .i_ready(i_ready_v[0]),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_v[0]), .d_ready(d_ready_v[0]),
        .mem_read(mem_read_v[0]), .mem_write(mem_write_v[0]), .mem_addr(mem_addr_v[0]),
        .mem_wdata(mem_wdata_v[0]), .mem_rdata(mem_rdata_v[0]), .mem_ready(mem_ready_v[0]),
        .busy(busy_v[0]), .timeout_err(terr_v[0])
    );

    mem_arbiter #(.D_PRIORITY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata_v[1]), .i_ready(i_ready_v[1]),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_v[1]), .d_ready(d_ready_v[1]),
        .mem_read(mem_read_v[1]), .mem_write(mem_write_v[1]), .mem_addr(mem_addr_v[1]),
        .mem_wdata(mem_wdata_v[1]), .mem_rdata(mem_rdata_v[1]), .mem_ready(mem_ready_v[1]),
        .busy(busy_v[1]), .timeout_err(terr_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] line_of(input logic [27:0] a);
        return {4{4'hC, a}};
    endfunction

    // Memory model: ready in the MEM_WAIT-th strobe cycle, line derived from address.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || !(mem_read_v[k] | mem_write_v[k]) || hold) begin
                mcnt[k]        = 0;
                mem_ready_v[k] = 1'b0;
                mem_rdata_v[k] = '0;
            end else begin
                mcnt[k]        = mcnt[k] + 1;
                mem_ready_v[k] = (mcnt[k] == MEM_WAIT);
                mem_rdata_v[k] = line_of(mem_addr_v[k]);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic rst_check(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_flags%0d", tag, k),
                {mem_read_v[k], mem_write_v[k], i_ready_v[k], d_ready_v[k], busy_v[k], terr_v[k]}, '0);
            chk($sformatf("%s_addr%0d", tag, k), mem_addr_v[k], '0);
            chk($sformatf("%s_wdata%0d", tag, k), mem_wdata_v[k], '0);
            chk($sformatf("%s_ird%0d", tag, k), i_rdata_v[k], '0);
            chk($sformatf("%s_drd%0d", tag, k), d_rdata_v[k], '0);
        end
    endtask

    task automatic check_strobe(input string tag, input logic [1:0] gd, input logic dw);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_rd%0d", tag, k), mem_read_v[k], gd[k] ? !dw : 1'b1);
            chk($sformatf("%s_wr%0d", tag, k), mem_write_v[k], gd[k] & dw);
            chk($sformatf("%s_addr%0d", tag, k), mem_addr_v[k], gd[k] ? d_addr : i_addr);
            if (gd[k] && dw) chk($sformatf("%s_wd%0d", tag, k), mem_wdata_v[k], d_wdata);
        end
    endtask

    task automatic check_txn(input string tag, input logic [1:0] gd, input logic dw);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_irdy%0d", tag, k), i_ready_v[k], !gd[k]);
            chk($sformatf("%s_drdy%0d", tag, k), d_ready_v[k], gd[k]);
            if (!gd[k]) e_ird[k] = line_of(i_addr);
            else if (!dw) e_drd[k] = line_of(d_addr);
            chk($sformatf("%s_ird%0d", tag, k), i_rdata_v[k], e_ird[k]);
            chk($sformatf("%s_drd%0d", tag, k), d_rdata_v[k], e_drd[k]);
        end
    endtask

    task automatic wait_rdy(input string tag);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = i_ready_v[0] | d_ready_v[0];
        end
        chk({tag, "_seen"}, got, 1'b1);
    endtask

    initial begin
        logic got;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        hold     = 1'b0;
        i_read   = 1'b0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        i_addr   = '0;
        d_addr   = '0;
        d_wdata  = '0;
        for (int k = 0; k < 2; k++) begin
            e_ird[k] = '0;
            e_drd[k] = '0;
        end

        rows[0] = '{1'b1, 1'b0, 1'b0, 28'h0000020, 28'h0000040, 128'h0, 2'b00};
        rows[1] = '{1'b0, 1'b1, 1'b0, 28'h0000021, 28'h0000041, 128'h0, 2'b11};
        rows[2] = '{1'b1, 1'b1, 1'b0, 28'h0000022, 28'h0000042, 128'h0, 2'b10};
        rows[3] = '{1'b1, 1'b1, 1'b0, 28'h0000023, 28'h0000043, 128'h0, 2'b11};
        rows[4] = '{1'b1, 1'b0, 1'b1, 28'h0000024, 28'h0000044, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2'b10};
        rows[5] = '{1'b0, 1'b0, 1'b1, 28'h0000025, 28'h00000A0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 2'b11};
        rows[6] = '{1'b0, 1'b1, 1'b1, 28'h0000026, 28'h0000046, 128'hCAFE_F00D_0000_0000_0000_0000_1234_5678, 2'b11};
        rows[7] = '{1'b1, 1'b1, 1'b1, 28'h0000027, 28'h0000047, 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0, 2'b10};

        repeat (2) @(negedge clk);
        rst_check("reset");
        rst = 1'b0;
        @(negedge clk);

        // Both caches hold reads for three transactions: RR gives D,I,D; D-priority gives D,D,D.
        i_addr = 28'h0000100;
        d_addr = 28'h0000200;
        i_read = 1'b1;
        d_read = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_rdy($sformatf("tie%0d", t));
            check_txn($sformatf("tie%0d", t), {1'b1, (t != 1)}, 1'b0);
        end
        i_read = 1'b0;
        d_read = 1'b0;
        @(negedge clk);
        chk("tie_idle", {busy_v[0], busy_v[1]}, 2'b00);

        // I-only read at 0x10, cycle-exact latency.
        i_addr = 28'h0000010;
        i_read = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("iread_c%0d", c), {mem_read_v[0], i_ready_v[0], d_ready_v[0], busy_v[0]},
                {(c <= 5), (c == 6), 1'b0, (c <= 6)});
            if (c == 1) chk("iread_addr", mem_addr_v[0], 28'h0000010);
            if (c == 6) begin
                e_ird[0] = line_of(28'h0000010);
                e_ird[1] = line_of(28'h0000010);
                chk("iread_data", i_rdata_v[0], e_ird[0]);
                i_read = 1'b0;
            end
        end

        // Table of single-transaction vectors.
        for (int r = 0; r < 8; r++) begin
            i_read  = rows[r].ir;
            d_read  = rows[r].dr;
            d_write = rows[r].dw;
            i_addr  = rows[r].ia;
            d_addr  = rows[r].da;
            d_wdata = rows[r].wd;
            @(negedge clk);
            check_strobe($sformatf("row%0d", r), rows[r].gd, rows[r].dw);
            wait_rdy($sformatf("row%0d", r));
            check_txn($sformatf("row%0d", r), rows[r].gd, rows[r].dw);
            i_read  = 1'b0;
            d_read  = 1'b0;
            d_write = 1'b0;
            @(negedge clk);
            chk($sformatf("row%0d_idle", r), {busy_v[0], busy_v[1]}, 2'b00);
        end

        // D write arrives while I is busy: no overlap, stable address, D starts after DONE.
        i_addr = 28'h0000300;
        i_read = 1'b1;
        @(negedge clk);
        check_strobe("dI_i", 2'b00, 1'b0);
        d_addr  = 28'h00003A0;
        d_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        d_write = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (i_ready_v[0]) got = 1'b1;
            else chk("dI_stable", {mem_write_v[0], mem_read_v[0], d_ready_v[0], mem_addr_v[0]},
                     {1'b0, 1'b1, 1'b0, 28'h0000300});
        end
        chk("dI_seen", got, 1'b1);
        check_txn("dI_i", 2'b00, 1'b0);
        i_read = 1'b0;
        @(negedge clk);
        chk("dI_gap", {mem_read_v[0], mem_write_v[0], busy_v[0]}, 3'b000);
        @(negedge clk);
        check_strobe("dI_d", 2'b11, 1'b1);
        wait_rdy("dI_d");
        check_txn("dI_d", 2'b11, 1'b1);
        d_write = 1'b0;
        @(negedge clk);

        // Watchdog: withhold mem_ready for 300 busy cycles.
        hold   = 1'b1;
        i_addr = 28'h0000400;
        i_read = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 300; c++) begin
            if (c == 250) chk("wd_early", terr_v[0], 1'b0);
            if (c == 257) chk("wd_set", terr_v[0], 1'b1);
            if (c == 300) chk("wd_wait", {terr_v[0], busy_v[0], mem_read_v[0]}, 3'b111);
            if (c < 300) @(negedge clk);
        end
        hold = 1'b0;
        wait_rdy("wd_done");
        check_txn("wd_done", 2'b00, 1'b0);
        i_read = 1'b0;
        @(negedge clk);
        chk("wd_sticky", {terr_v[0], busy_v[0]}, 2'b10);

        // Asynchronous reset in the middle of a transaction.
        i_addr = 28'h0000500;
        i_read = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_pre", {busy_v[0], mem_read_v[0]}, 2'b11);
        #2 rst = 1'b1;
        #1 rst_check("arst");
        i_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("arst_quiet%0d", c), {i_ready_v[0], d_ready_v[0], busy_v[0], mem_read_v[0], terr_v[0]}, 5'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
